// File: rtl/mmio_bus_ctrl.sv
// MMIO data-port sequencer: region decode, one-hot select, ack/timeout wait, sticky error capture.
// Latency: select 1 cycle after the request edge, cpu_ack 1 cycle after dev_ack; the CPU holds cpu_req until cpu_ack.
module mmio_bus_ctrl #(
    parameter int              NDEV     = 10,
    parameter logic [11:0]     DEV_BASE = 12'h001,
    parameter logic [NDEV-1:0] RO_MASK  = 10'b0111111000,
    parameter int              TIMEOUT  = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    input  logic [2:0]           cpu_memop_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 cpu_ack_o,
    output logic                 cpu_err_o,
    output logic [NDEV-1:0]      dev_sel_o,
    output logic                 dev_we_o,
    output logic [19:0]          dev_addr_o,
    output logic [31:0]          dev_wdata_o,
    output logic [2:0]           dev_memop_o,
    input  logic [32*NDEV-1:0]   dev_rdata_i,
    input  logic [NDEV-1:0]      dev_ack_i,
    output logic [1:0]           err_code_o,
    output logic [31:0]          err_addr_o,
    input  logic                 err_clr_i
);

    localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNTW-1:0]   cnt_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        memop_q;
    logic [NDEV-1:0]   dev_sel_q;
    logic              dev_we_q;
    logic              cpu_ack_q;
    logic              cpu_err_q;
    logic [31:0]       cpu_rdata_q;
    logic [1:0]        err_code_q;
    logic [31:0]       err_addr_q;

    logic [11:0]       region;
    logic [11:0]       idx;
    logic              region_ok;
    logic              ro_hit;
    logic              access_ok;
    logic [NDEV-1:0]   sel_dec;
    logic              ack_hit;
    logic              tmo_hit;
    logic [31:0]       rd_mux;
    logic              err_new_d;
    logic [1:0]        err_code_d;
    logic [31:0]       err_addr_d;

    // Decode in 12-bit unsigned arithmetic so regions below DEV_BASE wrap to a large idx and fail.
    always_comb begin
        region    = cpu_addr_i[31:20];
        idx       = region - DEV_BASE;
        region_ok = (region >= DEV_BASE) && (idx < 12'(NDEV));
        sel_dec   = '0;
        ro_hit    = 1'b0;
        for (int i = 0; i < NDEV; i++) begin
            if (idx == 12'(i)) begin
                sel_dec[i] = 1'b1;
                ro_hit     = RO_MASK[i];
            end
        end
        access_ok = region_ok && !(cpu_we_i && ro_hit);
    end

    // Masking with the registered select makes acks from unselected devices invisible.
    always_comb begin
        ack_hit = |(dev_ack_i & dev_sel_q);
        tmo_hit = (cnt_q == CNTW'(TIMEOUT - 1));
        rd_mux  = '0;
        for (int i = 0; i < NDEV; i++) begin
            rd_mux = rd_mux | (dev_rdata_i[32*i +: 32] & {32{dev_sel_q[i]}});
        end
    end

    always_comb begin
        err_new_d  = 1'b0;
        err_code_d = 2'd0;
        err_addr_d = 32'd0;
        if (state_q == ST_IDLE && cpu_req_i && !access_ok) begin
            err_new_d  = 1'b1;
            err_code_d = cpu_we_i ? 2'd2 : 2'd1;
            err_addr_d = cpu_addr_i;
        end else if (state_q == ST_WAIT && !ack_hit && tmo_hit) begin
            err_new_d  = 1'b1;
            err_code_d = 2'd3;
            err_addr_d = addr_q;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            memop_q     <= '0;
            dev_sel_q   <= '0;
            dev_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            err_code_q  <= '0;
            err_addr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cpu_ack_q   <= 1'b0;
                    cpu_err_q   <= 1'b0;
                    cpu_rdata_q <= '0;
                    if (cpu_req_i) begin
                        addr_q  <= cpu_addr_i;
                        wdata_q <= cpu_wdata_i;
                        memop_q <= cpu_memop_i;
                        if (access_ok) begin
                            dev_sel_q <= sel_dec;
                            dev_we_q  <= cpu_we_i;
                            cnt_q     <= '0;
                            state_q   <= ST_WAIT;
                        end else begin
                            cpu_ack_q <= 1'b1;
                            cpu_err_q <= 1'b1;
                            state_q   <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (ack_hit) begin
                        dev_sel_q   <= '0;
                        dev_we_q    <= 1'b0;
                        cnt_q       <= '0;
                        cpu_ack_q   <= 1'b1;
                        cpu_err_q   <= 1'b0;
                        cpu_rdata_q <= dev_we_q ? 32'd0 : rd_mux;
                        state_q     <= ST_RESP;
                    end else if (tmo_hit) begin
                        dev_sel_q   <= '0;
                        dev_we_q    <= 1'b0;
                        cnt_q       <= '0;
                        cpu_ack_q   <= 1'b1;
                        cpu_err_q   <= 1'b1;
                        cpu_rdata_q <= '0;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    cpu_ack_q   <= 1'b0;
                    cpu_err_q   <= 1'b0;
                    cpu_rdata_q <= '0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    dev_sel_q <= '0;
                    dev_we_q  <= 1'b0;
                    cpu_ack_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase

            // First error is sticky; a clear coinciding with a new error keeps the new one.
            if (err_new_d && (err_code_q == 2'd0 || err_clr_i)) begin
                err_code_q <= err_code_d;
                err_addr_q <= err_addr_d;
            end else if (err_clr_i) begin
                err_code_q <= '0;
                err_addr_q <= '0;
            end
        end
    end

    assign cpu_rdata_o = cpu_rdata_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign cpu_err_o   = cpu_err_q;
    assign dev_sel_o   = dev_sel_q;
    assign dev_we_o    = dev_we_q;
    assign dev_addr_o  = addr_q[19:0];
    assign dev_wdata_o = wdata_q;
    assign dev_memop_o = memop_q;
    assign err_code_o  = err_code_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Bench for mmio_bus_ctrl: directed plan cases then random accesses against a cycle-count reference model.
module tb_mmio_bus_ctrl;

    localparam int         NDEV = 10;
    localparam int         TO   = 16;
    localparam logic [9:0] RO   = 10'b0111111000;

    logic               clock = 1'b0;
    logic               reset;
    logic               cpu_req;
    logic               cpu_we;
    logic [31:0]        cpu_addr;
    logic [31:0]        cpu_wdata;
    logic [2:0]         cpu_memop;
    logic [31:0]        cpu_rdata;
    logic               cpu_ack;
    logic               cpu_err;
    logic [NDEV-1:0]    dev_sel;
    logic               dev_we;
    logic [19:0]        dev_addr;
    logic [31:0]        dev_wdata;
    logic [2:0]         dev_memop;
    logic [32*NDEV-1:0] dev_rdata;
    logic [NDEV-1:0]    dev_ack;
    logic [1:0]         err_code;
    logic [31:0]        err_addr;
    logic               err_clr;

    always #5 clock = ~clock;

    mmio_bus_ctrl dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_memop_i (cpu_memop),
        .cpu_rdata_o (cpu_rdata),
        .cpu_ack_o   (cpu_ack),
        .cpu_err_o   (cpu_err),
        .dev_sel_o   (dev_sel),
        .dev_we_o    (dev_we),
        .dev_addr_o  (dev_addr),
        .dev_wdata_o (dev_wdata),
        .dev_memop_o (dev_memop),
        .dev_rdata_i (dev_rdata),
        .dev_ack_i   (dev_ack),
        .err_code_o  (err_code),
        .err_addr_o  (err_addr),
        .err_clr_i   (err_clr)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference state: sticky error register and the last latched request fields.
    logic [1:0]  m_code;
    logic [31:0] m_eaddr;
    logic [19:0] m_daddr;
    logic [31:0] m_wdata;
    logic [2:0]  m_mop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_code  = 2'd0;
        m_eaddr = 32'd0;
        m_daddr = 20'd0;
        m_wdata = 32'd0;
        m_mop   = 3'd0;
    endtask

    task automatic err_step(input logic clr, input logic nv, input logic [1:0] code, input logic [31:0] a);
        if (nv && (m_code == 2'd0 || clr)) begin
            m_code  = code;
            m_eaddr = a;
        end else if (clr) begin
            m_code  = 2'd0;
            m_eaddr = 32'd0;
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_code"}, 32'(err_code), 32'(m_code));
        chk({tag, "_eaddr"}, err_addr, m_eaddr);
        chk({tag, "_daddr"}, 32'(dev_addr), 32'(m_daddr));
        chk({tag, "_wdata"}, dev_wdata, m_wdata);
        chk({tag, "_memop"}, 32'(dev_memop), 32'(m_mop));
    endtask

    // Idle cycles with random acks on the bus; nothing may be selected or acknowledged.
    task automatic idle(input int n, input logic clr);
        for (int k = 0; k < n; k++) begin
            cpu_req = 1'b0;
            err_clr = clr;
            dev_ack = NDEV'($urandom);
            @(negedge clock);
            chk("idle_sel", 32'(dev_sel), 32'd0);
            chk("idle_ack", 32'(cpu_ack), 32'd0);
            chk_regs("idle");
            @(posedge clock);
            err_step(clr, 1'b0, 2'd0, 32'd0);
            #1;
        end
        err_clr = 1'b0;
        dev_ack = '0;
    endtask

    // One CPU access. The selected device acks in WAIT cycle delay+1 (delay<0: never).
    // Cycle 0 ends with the sampling edge; every cycle through the response is checked.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] mop, input int delay, input logic stray, input int clr_c);
        logic [11:0] rg;
        int          idx;
        logic        bad;
        logic        fail;
        int          rc;
        logic [1:0]  code;
        logic [9:0]  sb;
        logic [31:0] exp_rd;
        logic        in_wait;
        rg  = addr[31:20];
        idx = 0;
        bad = 1'b1;
        if (rg >= 12'd1 && rg <= 12'd10) begin
            idx = int'(rg) - 1;
            bad = we && RO[idx];
        end
        sb = bad ? 10'd0 : 10'(1 << idx);
        if (bad) begin
            rc = 1; fail = 1'b1; code = we ? 2'd2 : 2'd1;
        end else if (delay >= 0 && delay + 1 <= TO) begin
            rc = delay + 2; fail = 1'b0; code = 2'd0;
        end else begin
            rc = TO + 1; fail = 1'b1; code = 2'd3;
        end
        exp_rd    = (fail || we) ? 32'd0 : dev_rdata[32*idx +: 32];
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_memop = mop;
        for (int c = 0; c <= rc; c++) begin
            dev_ack = (stray ? (NDEV'($urandom) & ~sb) : 10'd0) |
                      ((!bad && c == delay + 1) ? sb : 10'd0);
            err_clr = (c == clr_c);
            in_wait = !bad && c >= 1 && c < rc;
            @(negedge clock);
            chk("sel", 32'(dev_sel), in_wait ? 32'(sb) : 32'd0);
            chk("dev_we", 32'(dev_we), in_wait ? 32'(we) : 32'd0);
            chk("ack", 32'(cpu_ack), 32'(c == rc));
            if (c == rc) begin
                chk("err", 32'(cpu_err), 32'(fail));
                chk("rdata", cpu_rdata, exp_rd);
            end
            chk_regs("acc");
            @(posedge clock);
            if (c == 0) begin
                m_daddr = addr[19:0];
                m_wdata = wd;
                m_mop   = mop;
            end
            err_step(c == clr_c, fail && (c == rc - 1), code, addr);
            #1;
        end
        cpu_req = 1'b0;
        err_clr = 1'b0;
        dev_ack = '0;
    endtask

    // Device-2 read aborted by reset in its third WAIT cycle.
    task automatic reset_mid();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0030_0000;
        dev_ack  = '0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        chk("rst_pre_sel", 32'(dev_sel), 32'h4);
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        chk("rst_sel", 32'(dev_sel), 32'd0);
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk_regs("rst");
        @(posedge clock);
        #1;
        idle(3, 1'b0);
    endtask

    task automatic rand_rdata();
        for (int i = 0; i < NDEV; i++) dev_rdata[32*i +: 32] = $urandom;
    endtask

    initial begin
        logic [11:0] rg;
        int          pick;
        int          dly;
        int          clr_c;
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_memop = '0;
        dev_ack   = '0;
        err_clr   = 1'b0;
        rand_rdata();
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk("reset_ack", 32'(cpu_ack), 32'd0);
        chk("reset_err", 32'(cpu_err), 32'd0);
        chk("reset_rdata", cpu_rdata, 32'd0);
        chk("reset_sel", 32'(dev_sel), 32'd0);
        chk("reset_we", 32'(dev_we), 32'd0);
        chk_regs("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(2, 1'b0);

        dev_rdata[31:0] = 32'h1234_5678;
        access(1'b0, 32'h0010_0040, 32'd0, 3'b010, 0, 1'b0, -1);
        access(1'b1, 32'h00A0_0000, 32'h0000_BEEF, 3'b010, 2, 1'b0, -1);
        access(1'b1, 32'h0040_0000, 32'hCAFE_0001, 3'b010, 0, 1'b0, -1);
        idle(1, 1'b1);
        access(1'b0, 32'hFFF0_0000, 32'd0, 3'b000, 0, 1'b0, -1);
        access(1'b0, 32'h0060_0000, 32'd0, 3'b010, -1, 1'b0, -1);
        idle(1, 1'b1);
        idle(1, 1'b0);
        access(1'b0, 32'h0060_0000, 32'd0, 3'b010, -1, 1'b0, -1);
        access(1'b0, 32'h0060_0004, 32'd0, 3'b010, 15, 1'b0, -1);
        access(1'b0, 32'h0000_0010, 32'd0, 3'b001, 0, 1'b0, 0);
        access(1'b0, 32'h00B0_0000, 32'd0, 3'b001, 0, 1'b0, -1);
        reset_mid();
        rand_rdata();
        access(1'b0, 32'h0030_0008, 32'd0, 3'b010, 2, 1'b1, -1);

        for (int it = 0; it < 300; it++) begin
            rand_rdata();
            pick = $urandom_range(0, 12);
            rg   = (pick == 12) ? 12'($urandom) : 12'(pick);
            pick = $urandom_range(0, 9);
            dly  = (pick <= 6) ? $urandom_range(0, 4) : (pick == 7) ? -1 : (pick == 8) ? 15 : 16;
            clr_c = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
            access(1'($urandom), {rg, 20'($urandom)}, $urandom, 3'($urandom), dly,
                   1'($urandom), clr_c);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
